// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, IDLE/RUN/LAP/PAUSE sequencing, timer gating and display select
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   i_btn_ss   raw start/stop button, active-low, asynchronous
//   i_btn_lr   raw lap/reset button, active-low, asynchronous
//   i_tick     one-cycle enable pulse from clkdiv
//   i_cnt      current timer count
//   o_tmr_en   tick gated by RUN/LAP
//   o_tmr_clr  one-cycle timer clear
//   o_disp_val registered display value (live count or lap value)
//   o_state    IDLE=00, RUN=01, LAP=10, PAUSE=11

module stopwatch_db #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [1:0]   sync;
    logic         level;
    logic         level_d;
    logic [W-1:0] cnt;

    // any cycle where the synchronised level agrees with the accepted one restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            press   <= level_d & ~level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_btn_ss,
    input  logic             i_btn_lr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_tmr_en,
    output logic             o_tmr_clr,
    output logic [CNT_W-1:0] o_disp_val,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             clr_nx;
    logic             lap_ld;
    logic [CNT_W-1:0] lap;
    logic             ss;
    logic             lr;

    stopwatch_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (i_btn_ss),
        .press (ss)
    );

    stopwatch_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (i_btn_lr),
        .press (lr)
    );

    // start/stop takes priority when both presses land in the same cycle
    always_comb begin
        state_nx = state;
        clr_nx   = 1'b0;
        lap_ld   = 1'b0;
        if (ss) begin
            state_nx = (state == RUN || state == LAP) ? PAUSE : RUN;
        end else if (lr) begin
            case (state)
                IDLE:  clr_nx = 1'b1;
                RUN: begin
                    state_nx = LAP;
                    lap_ld   = 1'b1;
                end
                LAP:   state_nx = RUN;
                PAUSE: begin
                    state_nx = IDLE;
                    clr_nx   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_tmr_clr  <= 1'b0;
            lap        <= '0;
            o_disp_val <= '0;
        end else begin
            state      <= state_nx;
            o_tmr_clr  <= clr_nx;
            o_disp_val <= (state == LAP) ? lap : i_cnt;
            if (lap_ld) lap <= i_cnt;
        end
    end

    assign o_state  = state;
    assign o_tmr_en = i_tick & (state == RUN || state == LAP);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl with a window-based debounce model
module tb_stopwatch_ctrl;
    localparam int DC = 4;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_LAP = 2'b10, S_PAUSE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_btn_ss = 1'b1;
    logic        i_btn_lr = 1'b1;
    logic        i_tick = 1'b0;
    logic [15:0] i_cnt = '0;
    logic        o_tmr_en;
    logic        o_tmr_clr;
    logic [15:0] o_disp_val;
    logic [1:0]  o_state;

    int total = 0;
    int bad = 0;
    int clr_seen = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btn_ss   (i_btn_ss),
        .i_btn_lr   (i_btn_lr),
        .i_tick     (i_tick),
        .i_cnt      (i_cnt),
        .o_tmr_en   (o_tmr_en),
        .o_tmr_clr  (o_tmr_clr),
        .o_disp_val (o_disp_val),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d t=%0t", name, act, lo, hi, $time);
        end
    endtask

    // tick every 3 cycles; the count rises on each tick unless pinned to hold_val
    int          phase = 0;
    logic        hold = 1'b0;
    logic [15:0] hold_val = '0;
    logic [15:0] tcnt = '0;
    always @(negedge clk) begin
        phase  = (phase + 1) % 3;
        i_tick = (phase == 0);
        if (hold) tcnt = hold_val;
        else if (i_tick) tcnt = tcnt + 16'd1;
        i_cnt = tcnt;
    end

    typedef struct packed {
        logic [1:0]  st;
        logic        clr;
        logic [15:0] disp;
    } exp_t;
    exp_t q[$];

    // reference: a level is accepted once the last DC synchronised samples all disagree with it;
    // a press acts on the FSM two edges after its acceptance
    bit          rh[2][2];
    bit          win[2][DC];
    int          nwin[2];
    bit          db[2];
    int          last_fall[2];
    int          k = 0;
    logic [1:0]  m_st;
    logic [15:0] m_lap;
    logic [15:0] m_disp;
    always @(posedge clk) begin
        bit raw[2];
        bit ev[2];
        bit clr;
        bit sv;
        bit diff;
        raw[0] = i_btn_ss;
        raw[1] = i_btn_lr;
        k++;
        clr = 1'b0;
        if (!rst_n) begin
            m_st = S_IDLE;
            m_lap = '0;
            m_disp = '0;
            for (int b = 0; b < 2; b++) begin
                rh[b][0] = 1'b1;
                rh[b][1] = 1'b1;
                nwin[b] = 0;
                db[b] = 1'b1;
                last_fall[b] = -10;
            end
        end else begin
            for (int b = 0; b < 2; b++) ev[b] = (last_fall[b] == k - 2);
            m_disp = (m_st == S_LAP) ? m_lap : i_cnt;
            if (ev[0]) begin
                m_st = (m_st == S_RUN || m_st == S_LAP) ? S_PAUSE : S_RUN;
            end else if (ev[1]) begin
                if (m_st == S_IDLE) clr = 1'b1;
                else if (m_st == S_RUN) begin m_st = S_LAP; m_lap = i_cnt; end
                else if (m_st == S_LAP) m_st = S_RUN;
                else begin m_st = S_IDLE; clr = 1'b1; end
            end
            for (int b = 0; b < 2; b++) begin
                sv = rh[b][0];
                rh[b][0] = rh[b][1];
                rh[b][1] = raw[b];
                for (int i = 0; i < DC - 1; i++) win[b][i] = win[b][i+1];
                win[b][DC-1] = sv;
                if (nwin[b] < DC) nwin[b]++;
                if (nwin[b] == DC) begin
                    diff = 1'b1;
                    for (int i = 0; i < DC; i++) if (win[b][i] == db[b]) diff = 1'b0;
                    if (diff) begin
                        db[b] = ~db[b];
                        if (!db[b]) last_fall[b] = k;
                    end
                end
            end
        end
        q.push_back('{m_st, clr, m_disp});
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty actual=0 entries required=1 t=%0t", $time);
        end else begin
            e = q.pop_front();
            chk("sb_state", o_state, e.st);
            chk("sb_clr", o_tmr_clr, e.clr);
            chk("sb_disp", o_disp_val, e.disp);
            chk("sb_tmr_en", o_tmr_en, i_tick & (e.st == S_RUN || e.st == S_LAP));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (o_tmr_clr) clr_seen++;
        end
    endtask

    task automatic btn(input bit ss, input bit lr, input int n);
        i_btn_ss = ss;
        i_btn_lr = lr;
        cyc(n);
    endtask

    task automatic wait_state(input logic [1:0] s, output int n);
        n = 0;
        while (o_state !== s && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        cyc(3);
        chk("rst_state", o_state, S_IDLE);
        chk("rst_disp", o_disp_val, 16'h0);
        chk("rst_clr", o_tmr_clr, 1'b0);
        chk("rst_en", o_tmr_en, 1'b0);
        rst_n = 1'b1;
        cyc(2);

        i_btn_ss = 1'b0;
        wait_state(S_RUN, n);
        chk_rng("ss_latency", n, DC + 3, DC + 5);
        cyc(20 - n - 1);
        btn(1, 1, 12);
        chk("run_after_release", o_state, S_RUN);

        btn(0, 1, 2);
        btn(1, 1, 1);
        btn(0, 1, 0);
        wait_state(S_PAUSE, n);
        chk_rng("bounce_latency", n, DC + 3, DC + 5);
        btn(0, 1, 10);
        btn(1, 1, 12);
        chk("bounce_one_event", o_state, S_PAUSE);

        btn(0, 1, 12);
        btn(1, 1, 12);
        chk("pause_to_run", o_state, S_RUN);

        hold_val = 16'h0123;
        hold = 1'b1;
        cyc(3);
        btn(1, 0, 12);
        chk("run_to_lap", o_state, S_LAP);
        hold = 1'b0;
        btn(1, 1, 12);
        chk("lap_disp_held", o_disp_val, 16'h0123);
        btn(1, 0, 12);
        btn(1, 1, 12);
        chk("lap_to_run", o_state, S_RUN);

        btn(0, 1, 12);
        btn(1, 1, 12);
        chk("run_to_pause", o_state, S_PAUSE);
        clr_seen = 0;
        btn(1, 0, 12);
        btn(1, 1, 12);
        chk("pause_to_idle", o_state, S_IDLE);
        chk("clr_pulses_pause", clr_seen, 1);
        clr_seen = 0;
        btn(1, 0, 12);
        btn(1, 1, 12);
        chk("idle_stays", o_state, S_IDLE);
        chk("clr_pulses_idle", clr_seen, 1);

        btn(0, 1, 12);
        btn(1, 1, 12);
        btn(0, 0, 12);
        btn(1, 1, 12);
        chk("both_pause", o_state, S_PAUSE);

        btn(0, 1, 12);
        btn(1, 1, 12);
        hold_val = 16'h0456;
        hold = 1'b1;
        btn(1, 0, 12);
        btn(1, 1, 4);
        chk("lap_before_rst", o_disp_val, 16'h0456);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_lap_state", o_state, S_IDLE);
        chk("rst_lap_disp", o_disp_val, 16'h0);
        rst_n = 1'b1;
        hold = 1'b0;

        repeat (60) begin
            int kind;
            bit s;
            bit l;
            kind = $urandom_range(0, 9);
            if (kind == 9) begin
                rst_n = 1'b0;
                cyc($urandom_range(1, 2));
                rst_n = 1'b1;
            end else begin
                s = !(kind < 4 || kind == 8);
                l = !(kind >= 4);
                if ($urandom_range(0, 1) == 1) begin
                    btn(s, l, $urandom_range(1, 3));
                    btn(1, 1, $urandom_range(1, 2));
                end
                btn(s, l, $urandom_range(1, 12));
                btn(1, 1, $urandom_range(1, 12));
            end
        end
        cyc(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
